// File: rtl/ntt_bu_scheduler.sv
// ntt_bu_scheduler: drives one BU2_NWC butterfly over an N-point in-place RAM to run a
// full negacyclic NTT. It issues one read pair and one twiddle address per cycle. The
// matching write-back pair follows PIPE = RD_LAT + BU_LAT cycles later. A PIPE-cycle drain
// between stages keeps the last write of a stage ahead of the first read of the next one.
// Optional feature: define NTT_SCHED_INTT_EN to add the inverse (Gentleman-Sande) schedule.
// That adds the inverse and bu_inv ports and a twiddle address one bit wider.
`ifndef D_width
`define D_width 16
`endif

module ntt_bu_scheduler #(
  parameter int N      = 64,
  parameter int LOG_N  = 6,
  parameter int D_W    = `D_width,
  parameter int RD_LAT = 1,
  parameter int BU_LAT = 1,
`ifdef NTT_SCHED_INTT_EN
  localparam int TW_W  = LOG_N + 1
`else
  localparam int TW_W  = LOG_N
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [D_W-1:0]   modulus_in,
`ifdef NTT_SCHED_INTT_EN
  input  logic             inverse,
  output logic             bu_inv,
`endif
  output logic             busy,
  output logic             done,
  output logic [LOG_N-1:0] stage,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_up,
  output logic [LOG_N-1:0] rd_addr_dn,
  output logic [TW_W-1:0]  tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_up,
  output logic [LOG_N-1:0] wr_addr_dn,
  output logic [D_W-1:0]   modulus
);

  localparam int PIPE = RD_LAT + BU_LAT;
  localparam logic [LOG_N-2:0] B_LAST = (LOG_N-1)'(N/2 - 1);
  localparam logic [7:0]       D_LAST = 8'(PIPE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [LOG_N-1:0] up;
    logic [LOG_N-1:0] dn;
    logic [TW_W-1:0]  tw;
  } rd_req_t;

  state_t           state;
  logic [LOG_N-2:0] b;
  logic [7:0]       d;
  logic             inv_in;
  logic             inv_q;
  logic [LOG_N-1:0] st0;
  logic [LOG_N-1:0] stage_nx;
  logic             last_stage;

  // Butterfly b of stage s: group j of width 2*half, offset k inside the group.
  function automatic rd_req_t bf_addr(input int bi, input int si, input logic inv);
    int half, j, k, base;
    rd_req_t r;
    half = N >> (si + 1);
    j    = bi >> (LOG_N - 1 - si);
    k    = bi & (half - 1);
    base = j * 2 * half + k;
    r.up = LOG_N'(base);
    r.dn = LOG_N'(base + half);
    r.tw = TW_W'((inv ? N : 0) + (1 << si) + j);
    return r;
  endfunction

`ifdef NTT_SCHED_INTT_EN
  assign inv_in = inverse;
  assign bu_inv = inv_q;
`else
  assign inv_in = 1'b0;
  assign inv_q  = 1'b0;
`endif

  // Forward walks stages upward, inverse walks them downward with the same addressing.
  assign st0        = inv_in ? LOG_N'(LOG_N - 1) : '0;
  assign stage_nx   = inv_q ? stage - LOG_N'(1) : stage + LOG_N'(1);
  assign last_stage = inv_q ? (stage == '0) : (stage == LOG_N'(LOG_N - 1));

  // Schedule FSM; every read-side output is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      b          <= '0;
      d          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stage      <= '0;
      rd_en      <= 1'b0;
      rd_addr_up <= '0;
      rd_addr_dn <= '0;
      tw_addr    <= '0;
      modulus    <= '0;
`ifdef NTT_SCHED_INTT_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= ISSUE;
          busy    <= 1'b1;
          modulus <= modulus_in;
`ifdef NTT_SCHED_INTT_EN
          inv_q   <= inverse;
`endif
          stage   <= st0;
          b       <= '0;
          d       <= '0;
          rd_en   <= 1'b1;
          {rd_addr_up, rd_addr_dn, tw_addr} <= bf_addr(0, int'(st0), inv_in);
        end
        ISSUE: if (b == B_LAST) begin
          state <= DRAIN;
          b     <= '0;
          d     <= '0;
          rd_en <= 1'b0;
        end else begin
          b <= b + 1'b1;
          {rd_addr_up, rd_addr_dn, tw_addr} <= bf_addr(int'(b) + 1, int'(stage), inv_q);
        end
        DRAIN: if (d == D_LAST) begin
          d <= '0;
          if (last_stage) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= ISSUE;
            stage <= stage_nx;
            b     <= '0;
            rd_en <= 1'b1;
            {rd_addr_up, rd_addr_dn, tw_addr} <= bf_addr(0, int'(stage_nx), inv_q);
          end
        end else begin
          d <= d + 8'd1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [PIPE:1]             vld_pipe;
  logic [PIPE:1][LOG_N-1:0]  up_pipe;
  logic [PIPE:1][LOG_N-1:0]  dn_pipe;

  // Write-back delay line: the read pair and strobe, PIPE cycles late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      up_pipe  <= '0;
      dn_pipe  <= '0;
    end else begin
      vld_pipe[1] <= rd_en;
      up_pipe[1]  <= rd_addr_up;
      dn_pipe[1]  <= rd_addr_dn;
      for (int i = 2; i <= PIPE; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        up_pipe[i]  <= up_pipe[i-1];
        dn_pipe[i]  <= dn_pipe[i-1];
      end
    end
  end

  assign wr_en      = vld_pipe[PIPE];
  assign wr_addr_up = up_pipe[PIPE];
  assign wr_addr_dn = dn_pipe[PIPE];

endmodule
